// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch controller states, 2-bit encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERROR = 2'd3
    } fetch_state_e;

    // Value loaded into the instruction register at reset and on flush.
    localparam logic [15:0] DEFAULT_NOP_INSTR = 16'h0000;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface instruction_fetch_if #(
    parameter int unsigned INST_W   = 16,
    parameter int unsigned I_ADDR_W = 12
);

    logic                imem_req;    // request, held until acknowledged
    logic [I_ADDR_W-1:0] imem_addr;   // request address, stable while imem_req
    logic                imem_ack;    // response valid
    logic [INST_W-1:0]   imem_rdata;  // instruction word returned with imem_ack

    // Fetch stage side: issues requests, receives data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: receives requests, returns data.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface : instruction_fetch_if

// File: rtl/fetch_watchdog.sv
// Bus watchdog: counts consecutive cycles a request waits for its acknowledge
// and pulses expire on the cycle the wait reaches TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,   // request outstanding and not acknowledged this cycle
    input  logic clear,      // acknowledge seen: restart the wait count
    output logic expire      // single-cycle pulse when the limit is reached
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_INT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next wait count and expire pulse; expiry fires during the final waiting cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        count_d = count_q;
        expire  = 1'b0;
        if (TIMEOUT_CYCLES == 0 || clear) begin
            count_d = '0;
        end else if (count_en) begin
            if (count_q == LAST) begin
                expire  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : fetch_watchdog

// File: rtl/instruction_fetch.sv
// Fetch stage: requests the word at pc from instruction memory, holds it in the
// instruction register for the decoder until execute retires it, supports
// flush (redirect) and reports bus faults through a sticky bus_error.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       INST_W         = 16,
    parameter int unsigned       I_ADDR_W       = 12,
    parameter int unsigned       TIMEOUT_CYCLES = 16,
    parameter logic [INST_W-1:0] NOP_INSTR      = DEFAULT_NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_enable,
    input  logic [I_ADDR_W-1:0] pc,
    input  logic                flush,
    input  logic                instr_retire,
    input  logic                error_clear,
    instruction_fetch_if.master imem,
    output logic [INST_W-1:0]   instruction,
    output logic [I_ADDR_W-1:0] instr_pc,
    output logic                instr_valid,
    output logic                bus_error
);

    fetch_state_e        state_q,       state_d;
    logic                imem_req_q,    imem_req_d;
    logic [I_ADDR_W-1:0] imem_addr_q,   imem_addr_d;
    logic [INST_W-1:0]   instruction_q, instruction_d;
    logic [I_ADDR_W-1:0] instr_pc_q,    instr_pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic                bus_error_q,   bus_error_d;
    logic                discard_q,     discard_d;   // in-flight response must be dropped

    logic wd_count_en;
    logic wd_expire;
    logic ack_hit;        // handshake completes this cycle
    logic drop_response;  // response belongs to a flushed request

    assign ack_hit       = imem_req_q & imem.imem_ack;
    assign drop_response = discard_q | flush;
    assign wd_count_en   = imem_req_q & ~imem.imem_ack;

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (wd_count_en),
        .clear    (imem.imem_ack),
        .expire   (wd_expire)
    );

    // Next-state and datapath decisions for the fetch controller.
    always_comb begin
        state_d       = state_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instruction_d = instruction_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        bus_error_d   = bus_error_q;
        discard_d     = discard_q;

        // An acknowledge with no request outstanding is a protocol fault.
        if (imem.imem_ack && !imem_req_q) begin
            bus_error_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fetch_enable) begin
                    state_d     = FETCH;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc;
                end
            end

            FETCH: begin
                if (wd_expire) begin
                    // Memory never answered: abandon the request and park in ERROR.
                    state_d     = ERROR;
                    imem_req_d  = 1'b0;
                    discard_d   = 1'b0;
                    bus_error_d = 1'b1;
                end else if (ack_hit) begin
                    if (drop_response) begin
                        // Stale word from before a flush: drop it and refetch from pc.
                        discard_d = 1'b0;
                        if (fetch_enable) begin
                            imem_addr_d = pc;
                        end else begin
                            imem_req_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end else begin
                        state_d       = VALID;
                        imem_req_d    = 1'b0;
                        instruction_d = imem.imem_rdata;
                        instr_pc_d    = imem_addr_q;
                        instr_valid_d = 1'b1;
                    end
                end else if (flush) begin
                    // The request stays up until acknowledged; only its data is voided.
                    discard_d = 1'b1;
                end
            end

            VALID: begin
                if (flush || instr_retire) begin
                    instr_valid_d = 1'b0;
                    if (flush) begin
                        instruction_d = NOP_INSTR;
                    end
                    if (fetch_enable) begin
                        state_d     = FETCH;
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            ERROR: begin
                if (error_clear) begin
                    bus_error_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Controller state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instruction_q <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            bus_error_q   <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            bus_error_q   <= bus_error_d;
            discard_q     <= discard_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = imem_addr_q;
    assign instruction    = instruction_q;
    assign instr_pc       = instr_pc_q;
    assign instr_valid    = instr_valid_q;
    assign bus_error      = bus_error_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_instruction_fetch;

    localparam int unsigned INST_W   = 16;
    localparam int unsigned I_ADDR_W = 12;
    localparam int unsigned TMO      = 4;
    localparam logic [15:0] NOP      = 16'h7F00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_enable;
    logic [11:0] pc;
    logic        flush;
    logic        instr_retire;
    logic        error_clear;
    logic [15:0] instruction;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [4096];

    instruction_fetch_if #(.INST_W(INST_W), .I_ADDR_W(I_ADDR_W)) bus ();

    instruction_fetch #(
        .INST_W         (INST_W),
        .I_ADDR_W       (I_ADDR_W),
        .TIMEOUT_CYCLES (TMO),
        .NOP_INSTR      (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_enable (fetch_enable),
        .pc           (pc),
        .flush        (flush),
        .instr_retire (instr_retire),
        .error_clear  (error_clear),
        .imem         (bus),
        .instruction  (instruction),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .bus_error    (bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    // {req, addr, valid, instruction, instr_pc, bus_error}
    function automatic logic [42:0] pack(input logic req, input logic [11:0] addr, input logic valid,
                                         input logic [15:0] ins, input logic [11:0] ipc, input logic err);
        return {req, addr, valid, ins, ipc, err};
    endfunction

    function automatic logic [42:0] snap();
        return {bus.imem_req, bus.imem_addr, instr_valid, instruction, instr_pc, bus_error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        fetch_enable   = 1'b0;
        pc             = '0;
        flush          = 1'b0;
        instr_retire   = 1'b0;
        error_clear    = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [42:0] e;
        apply_reset();
        e = pack(1'b0, 12'h000, 1'b0, NOP, 12'h000, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL reset_state got %h exp %h", snap(), e); end
    endtask

    task automatic test_fetch_basic();
        logic [42:0] e;
        fetch_enable = 1'b1; pc = 12'h010;
        tick();
        e = pack(1'b1, 12'h010, 1'b0, NOP, 12'h000, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t1_req_issue got %h exp %h", snap(), e); end
        pc = 12'h3FF;
        tick();
        checks++; if (snap() !== e) begin errors++; $display("FAIL t1_req_hold got %h exp %h", snap(), e); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hA5C3;
        tick();
        bus.imem_ack = 1'b0;
        e = pack(1'b0, 12'h010, 1'b1, 16'hA5C3, 12'h010, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t1_data_valid got %h exp %h", snap(), e); end
        tick();
        checks++; if (snap() !== e) begin errors++; $display("FAIL t1_valid_hold got %h exp %h", snap(), e); end
    endtask

    task automatic test_retire_refetch();
        logic [42:0] e;
        pc = 12'h011; instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        e = pack(1'b1, 12'h011, 1'b0, 16'hA5C3, 12'h010, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t2_retire_refetch got %h exp %h", snap(), e); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
        tick();
        bus.imem_ack = 1'b0;
        e = pack(1'b0, 12'h011, 1'b1, 16'h1234, 12'h011, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t2_second_fetch got %h exp %h", snap(), e); end
    endtask

    task automatic test_flush_fetch();
        logic [42:0] e;
        pc = 12'h020; instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        e = pack(1'b1, 12'h020, 1'b0, 16'h1234, 12'h011, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t3_req got %h exp %h", snap(), e); end
        flush = 1'b1; pc = 12'h030;
        tick();
        flush = 1'b0;
        checks++; if (snap() !== e) begin errors++; $display("FAIL t3_flush_no_ack got %h exp %h", snap(), e); end
        pc = 12'h040; bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
        tick();
        bus.imem_ack = 1'b0;
        e = pack(1'b1, 12'h040, 1'b0, 16'h1234, 12'h011, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t3_discard_reissue got %h exp %h", snap(), e); end
        pc = 12'h050; flush = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
        tick();
        flush = 1'b0; bus.imem_ack = 1'b0;
        e = pack(1'b1, 12'h050, 1'b0, 16'h1234, 12'h011, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t3_flush_with_ack got %h exp %h", snap(), e); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF;
        tick();
        bus.imem_ack = 1'b0;
        e = pack(1'b0, 12'h050, 1'b1, 16'hBEEF, 12'h050, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t3_clean_fetch got %h exp %h", snap(), e); end
        pc = 12'h060; flush = 1'b1;
        tick();
        flush = 1'b0;
        e = pack(1'b1, 12'h060, 1'b0, NOP, 12'h050, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t3_flush_valid got %h exp %h", snap(), e); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h0F0F;
        tick();
        bus.imem_ack = 1'b0; fetch_enable = 1'b0; instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        e = pack(1'b0, 12'h060, 1'b0, 16'h0F0F, 12'h060, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t3_retire_to_idle got %h exp %h", snap(), e); end
    endtask

    task automatic test_timeout();
        logic [42:0] e;
        apply_reset();
        fetch_enable = 1'b1; pc = 12'h100;
        tick();
        e = pack(1'b1, 12'h100, 1'b0, NOP, 12'h000, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t4_req got %h exp %h", snap(), e); end
        for (int i = 1; i < TMO; i++) begin
            tick();
            checks++; if (snap() !== e) begin errors++; $display("FAIL t4_wait_%0d got %h exp %h", i, snap(), e); end
        end
        tick();
        e = pack(1'b0, 12'h100, 1'b0, NOP, 12'h000, 1'b1);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t4_expire got %h exp %h", snap(), e); end
        tick();
        tick();
        checks++; if (snap() !== e) begin errors++; $display("FAIL t4_error_hold got %h exp %h", snap(), e); end
        error_clear = 1'b1; pc = 12'h101;
        tick();
        error_clear = 1'b0;
        e = pack(1'b0, 12'h100, 1'b0, NOP, 12'h000, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t4_clear got %h exp %h", snap(), e); end
        tick();
        e = pack(1'b1, 12'h101, 1'b0, NOP, 12'h000, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t4_refetch_req got %h exp %h", snap(), e); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hCAFE;
        tick();
        bus.imem_ack = 1'b0;
        e = pack(1'b0, 12'h101, 1'b1, 16'hCAFE, 12'h101, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t4_refetch_data got %h exp %h", snap(), e); end
    endtask

    task automatic test_protocol();
        logic [42:0] e;
        apply_reset();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        e = pack(1'b0, 12'h000, 1'b0, NOP, 12'h000, 1'b1);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t5_ack_without_req got %h exp %h", snap(), e); end
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        checks++; if (snap() !== e) begin errors++; $display("FAIL t5_clear_outside_error got %h exp %h", snap(), e); end
        fetch_enable = 1'b1; pc = 12'h200;
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h4321;
        tick();
        bus.imem_ack = 1'b0;
        e = pack(1'b0, 12'h200, 1'b1, 16'h4321, 12'h200, 1'b1);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t5_fetch_after_fault got %h exp %h", snap(), e); end
        fetch_enable = 1'b0; flush = 1'b1; instr_retire = 1'b1;
        tick();
        flush = 1'b0; instr_retire = 1'b0;
        e = pack(1'b0, 12'h200, 1'b0, NOP, 12'h200, 1'b1);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t5_flush_retire got %h exp %h", snap(), e); end
    endtask

    task automatic test_async_reset();
        logic [42:0] e;
        apply_reset();
        fetch_enable = 1'b1; pc = 12'h055;
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h9999;
        tick();
        bus.imem_ack = 1'b0; pc = 12'h056; instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        e = pack(1'b1, 12'h056, 1'b0, 16'h9999, 12'h055, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t6_pre_reset got %h exp %h", snap(), e); end
        #2 rst_n = 1'b0;
        #1;
        e = pack(1'b0, 12'h000, 1'b0, NOP, 12'h000, 1'b0);
        checks++; if (snap() !== e) begin errors++; $display("FAIL t6_async_reset got %h exp %h", snap(), e); end
        tick();
        drive_idle();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference model: one outstanding request (or none) and one held instruction.
    task automatic test_random();
        logic        m_req   = 1'b0;
        logic [11:0] m_addr  = '0;
        logic        m_dead  = 1'b0;
        logic        m_valid = 1'b0;
        logic [15:0] m_instr = NOP;
        logic [11:0] m_ipc   = '0;
        int          waited  = 0;
        logic        en, fl, rt, ack;
        logic [11:0] npc;

        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        apply_reset();

        for (int cyc = 0; cyc < 600; cyc++) begin
            en  = ($urandom_range(0, 9) != 0);
            npc = 12'($urandom);
            fl  = ($urandom_range(0, 11) == 0);
            rt  = m_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            ack = m_req && ((waited == int'(TMO) - 1) || ($urandom_range(0, 2) == 0));

            fetch_enable   = en;
            pc             = npc;
            flush          = fl;
            instr_retire   = rt;
            error_clear    = ($urandom_range(0, 15) == 0);
            bus.imem_ack   = ack;
            bus.imem_rdata = ack ? mem[bus.imem_addr] : 16'($urandom);

            if (m_req) begin
                if (ack) begin
                    waited = 0;
                    if (m_dead || fl) begin
                        m_dead = 1'b0;
                        if (en) m_addr = npc;
                        else    m_req  = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                        m_instr = mem[m_addr];
                        m_ipc   = m_addr;
                        m_req   = 1'b0;
                    end
                end else begin
                    waited++;
                    if (fl) m_dead = 1'b1;
                end
            end else if (m_valid) begin
                if (fl || rt) begin
                    m_valid = 1'b0;
                    if (fl) m_instr = NOP;
                    if (en) begin m_req = 1'b1; m_addr = npc; waited = 0; end
                end
            end else if (en) begin
                m_req = 1'b1; m_addr = npc; waited = 0;
            end

            tick();

            checks++; if (bus.imem_req !== m_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, bus.imem_req, m_req); end
            checks++; if (bus.imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, bus.imem_addr, m_addr); end
            checks++; if (instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, instr_valid, m_valid); end
            checks++; if (instruction !== m_instr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", cyc, instruction, m_instr); end
            checks++; if (instr_pc !== m_ipc) begin errors++; $display("FAIL rnd_instr_pc cyc %0d got %h exp %h", cyc, instr_pc, m_ipc); end
            checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rnd_bus_error cyc %0d got %b exp 0", cyc, bus_error); end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_fetch_basic();
        test_retire_refetch();
        test_flush_fetch();
        test_timeout();
        test_protocol();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch
